// File: rtl/dvp_capture_if.sv
// rtl/dvp_capture_if.sv - pixel stream and frame markers from dvp_capture to the TFT frame buffer
interface dvp_capture_if;
  logic        o_pixel_valid;
  logic [15:0] o_pixel_data;
  logic        o_frame_start;
  logic        o_line_end;
  logic        o_frame_done;
  logic        o_frame_err;
  logic        o_capturing;

  modport master (
    output o_pixel_valid,
    output o_pixel_data,
    output o_frame_start,
    output o_line_end,
    output o_frame_done,
    output o_frame_err,
    output o_capturing
  );

  modport slave (
    input o_pixel_valid,
    input o_pixel_data,
    input o_frame_start,
    input o_line_end,
    input o_frame_done,
    input o_frame_err,
    input o_capturing
  );
endinterface

// File: rtl/dvp_capture.sv
// rtl/dvp_capture.sv - OV5640 DVP capture into RGB565 pixels, oversampling cam_pclk in i_sysclk
// Define DVP_CAPTURE_TEST_PATTERN_EN to replace pixel data with an {x,y,x} test pattern.
module dvp_capture #(
  parameter int IMAGE_WIDTH  = 480,
  parameter int IMAGE_HEIGHT = 272,
  parameter int SKIP_FRAMES  = 10
) (
  input  logic          i_sysclk,
  input  logic          i_sysrst,
  input  logic          init_done,
  input  logic          cam_pclk,
  input  logic          cam_vsync,
  input  logic          cam_href,
  input  logic [7:0]    cam_data,
  dvp_capture_if.master pix
);
  localparam logic [9:0] WIDTH_C  = 10'(IMAGE_WIDTH);
  localparam logic [8:0] HEIGHT_C = 9'(IMAGE_HEIGHT);
  localparam logic [7:0] SKIP_C   = (SKIP_FRAMES > 255) ? 8'd255 : 8'(SKIP_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SKIP,
    ST_WAIT_SOF,
    ST_ACTIVE
  } state_t;

  logic [10:0] sync1_q, sync1_d;
  logic [10:0] sync2_q, sync2_d;
  logic        pclk_prev_q, pclk_prev_d;
  logic        vsync_last_q, vsync_last_d;
  logic        href_last_q, href_last_d;
  logic        cfg_ok_q, cfg_ok_d;
  state_t      state_q, state_d;
  logic [7:0]  skip_q, skip_d;
  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic        phase_q, phase_d;
  logic [7:0]  hi_q, hi_d;
  logic        valid_q, valid_d;
  logic [15:0] data_q, data_d;
  logic        fs_q, fs_d;
  logic        le_q, le_d;
  logic        fd_q, fd_d;
  logic        err_q, err_d;

  logic        pclk_s, vsync_s, href_s;
  logic [7:0]  data_s;
  logic        pclk_rise, vsync_rise, vsync_fall, href_fall;
  logic [9:0]  x_inc;
  logic [8:0]  y_inc;
  logic [7:0]  skip_inc;
  logic [15:0] pixel_word;

  // All four pad signals share one synchronizer chain so they keep equal delay.
  always_comb begin
    sync1_d = {cam_pclk, cam_vsync, cam_href, cam_data};
    sync2_d = sync1_q;
  end

  assign pclk_s  = sync2_q[10];
  assign vsync_s = sync2_q[9];
  assign href_s  = sync2_q[8];
  assign data_s  = sync2_q[7:0];

  assign pclk_rise  = pclk_s & ~pclk_prev_q;
  assign vsync_rise = pclk_rise & vsync_s & ~vsync_last_q;
  assign vsync_fall = pclk_rise & ~vsync_s & vsync_last_q;
  assign href_fall  = pclk_rise & ~href_s & href_last_q;

  assign x_inc    = (x_q == 10'h3ff) ? x_q : x_q + 10'd1;
  assign y_inc    = (y_q == 9'h1ff) ? y_q : y_q + 9'd1;
  assign skip_inc = (skip_q == 8'hff) ? skip_q : skip_q + 8'd1;

`ifdef DVP_CAPTURE_TEST_PATTERN_EN
  assign pixel_word = {x_q[8:4], y_q[7:2], x_q[8:4]};
`else
  assign pixel_word = {hi_q, data_s};
`endif

  always_comb begin
    pclk_prev_d  = pclk_s;
    vsync_last_d = pclk_rise ? vsync_s : vsync_last_q;
    href_last_d  = pclk_rise ? href_s : href_last_q;
    cfg_ok_d     = cfg_ok_q | init_done;
    state_d      = state_q;
    skip_d       = skip_q;
    x_d          = x_q;
    y_d          = y_q;
    phase_d      = phase_q;
    hi_d         = hi_q;
    valid_d      = 1'b0;
    data_d       = data_q;
    fs_d         = 1'b0;
    le_d         = 1'b0;
    fd_d         = 1'b0;
    err_d        = err_q;

    case (state_q)
      ST_IDLE: begin
        if (cfg_ok_q) begin
          state_d = ST_SKIP;
          skip_d  = 8'd0;
        end
      end

      ST_SKIP: begin
        if (SKIP_C == 8'd0) begin
          state_d = ST_WAIT_SOF;
        end else if (vsync_rise) begin
          skip_d = skip_inc;
          if (skip_inc >= SKIP_C) state_d = ST_WAIT_SOF;
        end
      end

      ST_WAIT_SOF: begin
        if (vsync_fall) begin
          fs_d    = 1'b1;
          err_d   = 1'b0;
          x_d     = 10'd0;
          y_d     = 9'd0;
          phase_d = 1'b0;
          state_d = ST_ACTIVE;
        end
      end

      ST_ACTIVE: begin
        // vsync takes priority: any half-received pixel is simply dropped.
        if (vsync_rise) begin
          fd_d    = 1'b1;
          phase_d = 1'b0;
          if (y_q != HEIGHT_C) err_d = 1'b1;
          state_d = ST_WAIT_SOF;
        end else if (pclk_rise && href_s) begin
          if (!phase_q) begin
            hi_d    = data_s;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            x_d     = x_inc;
            if (x_q < WIDTH_C && y_q < HEIGHT_C) begin
              valid_d = 1'b1;
              data_d  = pixel_word;
              le_d    = (x_q == WIDTH_C - 10'd1);
            end else begin
              err_d = 1'b1;
            end
          end
        end else if (pclk_rise) begin
          phase_d = 1'b0;
          if (href_fall && x_q != 10'd0) begin
            y_d = y_inc;
            x_d = 10'd0;
            if (x_q != WIDTH_C || phase_q) err_d = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_sysclk or posedge i_sysrst) begin
    if (i_sysrst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      pclk_prev_q  <= 1'b0;
      vsync_last_q <= 1'b0;
      href_last_q  <= 1'b0;
      cfg_ok_q     <= 1'b0;
      state_q      <= ST_IDLE;
      skip_q       <= 8'd0;
      x_q          <= 10'd0;
      y_q          <= 9'd0;
      phase_q      <= 1'b0;
      hi_q         <= 8'd0;
      valid_q      <= 1'b0;
      data_q       <= 16'd0;
      fs_q         <= 1'b0;
      le_q         <= 1'b0;
      fd_q         <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      pclk_prev_q  <= pclk_prev_d;
      vsync_last_q <= vsync_last_d;
      href_last_q  <= href_last_d;
      cfg_ok_q     <= cfg_ok_d;
      state_q      <= state_d;
      skip_q       <= skip_d;
      x_q          <= x_d;
      y_q          <= y_d;
      phase_q      <= phase_d;
      hi_q         <= hi_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      fs_q         <= fs_d;
      le_q         <= le_d;
      fd_q         <= fd_d;
      err_q        <= err_d;
    end
  end

  assign pix.o_pixel_valid = valid_q;
  assign pix.o_pixel_data  = data_q;
  assign pix.o_frame_start = fs_q;
  assign pix.o_line_end    = le_q;
  assign pix.o_frame_done  = fd_q;
  assign pix.o_frame_err   = err_q;
  assign pix.o_capturing   = (state_q == ST_WAIT_SOF) || (state_q == ST_ACTIVE);
endmodule
